// File: rtl/shift_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter: one barrel stage per clock,
// operands in and results out over valid/ready handshakes.
module shift_right_sequential #(
   parameter int N = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         in,
   input  logic [$clog2(N)-1:0] shamt,
   input  logic                 arith,
   input  logic                 i_valid,
   output logic                 i_ready,
   output logic [N-1:0]         out,
   output logic                 o_valid,
   input  logic                 o_ready
);

   localparam int L  = $clog2(N);
   localparam int SW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t         state_reg;
   logic [N-1:0]   data_reg;
   logic [L-1:0]   shamt_reg;
   logic           arith_reg;
   logic           sign_reg;
   logic [SW-1:0]  stage_reg;

   logic           fill;
   logic [N-1:0]   stage_out [L];
   logic [N-1:0]   data_next;

   // Sign is kept in its own register, captured at accept time.
   assign fill = arith_reg & sign_reg;

   generate
      for (genvar gi = 0; gi < L; gi++) begin : g_stage
         assign stage_out[gi] = {{(2**gi){fill}}, data_reg[N-1:2**gi]};
      end
   endgenerate

   always_comb begin
      data_next = data_reg;
      for (int i = 0; i < L; i++) begin
         if (stage_reg == SW'(i) && shamt_reg[i]) begin
            data_next = stage_out[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         data_reg  <= '0;
         shamt_reg <= '0;
         arith_reg <= 1'b0;
         sign_reg  <= 1'b0;
         stage_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (i_valid) begin
                  data_reg  <= in;
                  shamt_reg <= shamt;
                  arith_reg <= arith;
                  sign_reg  <= in[N-1];
                  stage_reg <= '0;
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               data_reg  <= data_next;
               stage_reg <= stage_reg + SW'(1);
               if (stage_reg == SW'(L-1)) begin
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               if (o_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign i_ready = !rst && (state_reg == S_IDLE);
   assign o_valid = !rst && (state_reg == S_DONE);
   assign out     = rst ? '0 : data_reg;

endmodule
